rvvi_tx_arbiter: RTL and testbench
==================================

# rvvi_tx_arbiter

Frame-atomic arbiter and credit scheduler for the RVVI Ethernet transmit path. Shares one 32-bit AXI4 write-data channel into the MAC TX FIFO between two requesters: the trace packetizer (requester T) and the host-control frame source (requester C, which sends acks and heartbeats). Round-robin grants are held for a whole frame. Trace frames are gated by a credit window that is replenished by cumulative host acknowledgements. The block also owns the trace frame counter that the packetizer embeds in each frame.

## Interface
- MAX_OUTSTANDING, 8: maximum trace frames sent but not yet acked; legal range 1..255.
- FRAME_COUNT_WIDTH, 64: width of the frame and ack counters.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- TWdata/TWstrb/TWlast/TWvalid  in  32/4/1/1  trace requester write-data channel.
- TWready  out  1  ready to trace requester.
- CWdata/CWstrb/CWlast/CWvalid  in  32/4/1/1  control requester write-data channel.
- CWready  out  1  ready to control requester.
- MWdata/MWstrb/MWlast/MWvalid  out  32/4/1/1  merged channel to MAC TX.
- MWready  in  1  MAC TX ready.
- AckValid  in  1  single-cycle strobe: a host ack has been decoded.
- AckCount  in  FRAME_COUNT_WIDTH  cumulative count of trace frames the host has received.
- FrameCount  out  FRAME_COUNT_WIDTH  trace frames fully sent; goes to the packetizer FrameCount input.
- Outstanding  out  8  FrameCount minus AckedCount.
- CreditStall  out  1  Outstanding == MAX_OUTSTANDING.

## Operation
- States: IDLE, GNT_T, GNT_C. Reset enters IDLE.
- Reset values: FrameCount=0, AckedCount=0, LastGrant=C (so T wins the first tie), Outstanding=0, CreditStall=0. MWvalid, TWready, CWready and MWlast are all 0.
- CreditOk = Outstanding < MAX_OUTSTANDING.
- Eligibility in IDLE: T is eligible when TWvalid & CreditOk. C is eligible when CWvalid. C is never credit-gated.
- IDLE, one requester eligible: go to its GNT state.
- IDLE, both eligible: grant the one that is not LastGrant, then set LastGrant to it.
- IDLE, none eligible: stay in IDLE.
- In GNT_x:
  - MW* = xW*.
  - xWready = MWready; the other ready is 0.
  - MWvalid = xWvalid.
- Frame end is MWvalid & MWready & MWlast while in GNT_x. At frame end: go to IDLE. If x == T, also FrameCount += 1.
- In IDLE: MWvalid=0, both readies 0, MWdata=0, MWstrb=0, MWlast=0.
- A grant is never preempted mid-frame, and credits are not rechecked inside GNT_T. A frame that has started always completes.
- Ack acceptance: on AckValid, accept when AckedCount <= AckCount <= FrameCount (unsigned, using next-cycle FrameCount ordering rules below). On accept, AckedCount <= AckCount. Stale or future acks are ignored silently.
- Outstanding = FrameCount - AckedCount. This is registered-state arithmetic in FRAME_COUNT_WIDTH, truncated to 8 bits. Its value never exceeds MAX_OUTSTANDING.
- Counter wrap: FrameCount wraps modulo 2^FRAME_COUNT_WIDTH. The ack range check is performed on differences: (AckCount-AckedCount) <= (FrameCount-AckedCount). This keeps the check correct across the wrap.

## Timing
- Grant latency: the requester's valid is sampled in IDLE, and the GNT state plus the first transfer opportunity occur on the next cycle.
- Minimum inter-frame gap on MW: 1 idle cycle (the IDLE state after frame end). Beats within a frame may be back-to-back.
- FrameCount updates on the clock edge after the T frame-end beat. It is visible to the packetizer from the next cycle.
- Ack and frame end in the same cycle: the ack is checked against the pre-increment FrameCount, and both updates apply on the same edge.
- CreditStall and Outstanding reflect registered state; they change one cycle after a frame end or an accepted ack.
- Reset mid-frame: returns to IDLE immediately and drops the partial frame. Requesters are reset by the same reset.
- The MW channel is a pass-through: combinational from xW* and MWready, with no buffering.

## Test plan
- Single T frame of 20 beats with MWready=1: grant in cycle 1, 20 beats, MWlast on beat 20, FrameCount 0->1, Outstanding=1.
- T and C both valid from reset: T granted first, C granted second after a 1-cycle IDLE gap. Repeat the pair 3 times; grants must alternate T,C,T,C,T,C.
- MAX_OUTSTANDING=8, no acks, T streams continuously: 8 frames are sent, then CreditStall=1 and TWready stays 0. C frames are still granted. An ack with AckCount=5 brings Outstanding to 3 and T resumes the next cycle.
- Ack checks with FrameCount=4, AckedCount=2: AckCount=6 (future) is ignored, AckCount=1 (stale) is ignored, AckCount=4 is accepted and gives Outstanding=0.
- Random MWready backpressure (about 50%) during a 30-beat C frame while TWvalid=1: no T beat leaks, C data order is preserved, and T is granted only after C's MWlast handshake.
- FrameCount preset near 2^64-1 (via forced state) with acks following it: wraps to 0, and acks across the wrap are accepted with correct Outstanding. Separately, a reset asserted mid-frame returns all outputs to reset values on the next cycle.

Source files
------------

// File: rtl/rvvi_tx_arbiter_if.sv
// rvvi_tx_arbiter_if
//   AXI4-style write-data channel (data, byte strobes, last, valid/ready)
//   shared by the RVVI transmit requesters and the MAC TX FIFO.
// Signals:
//   Wdata  32  write data
//   Wstrb   4  byte strobes
//   Wlast   1  final beat of a frame
//   Wvalid  1  beat valid (source to sink)
//   Wready  1  beat accepted (sink to source)
// Modports: master drives the beat and samples Wready; slave is the reverse.
interface rvvi_tx_arbiter_if;
  logic [31:0] Wdata;
  logic [3:0]  Wstrb;
  logic        Wlast;
  logic        Wvalid;
  logic        Wready;

  modport master (output Wdata, output Wstrb, output Wlast, output Wvalid, input Wready);
  modport slave  (input Wdata, input Wstrb, input Wlast, input Wvalid, output Wready);
endinterface

// File: rtl/rvvi_tx_arbiter.sv
// rvvi_tx_arbiter
//   Frame-atomic round-robin arbiter between the trace packetizer (T) and
//   the host-control frame source (C) onto the MAC TX write-data channel.
//   Trace frames are credit-gated by a window of MAX_OUTSTANDING unacked
//   frames; cumulative host acks reopen the window. Also owns the trace
//   frame counter embedded by the packetizer.
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   tReq          trace requester channel (slave)
//   cReq          control requester channel (slave)
//   mTx           merged channel to MAC TX (master)
//   AckValid      one-cycle strobe, host ack decoded
//   AckCount      cumulative trace frames received by the host
//   FrameCount    trace frames fully sent
//   Outstanding   FrameCount - acked count, 8 bits
//   CreditStall   credit window is full
//
// state | meaning
// IDLE  | no grant; arbitrate on this cycle's valids, MW outputs held at 0
// GNT_T | trace requester owns MW until its last-beat handshake
// GNT_C | control requester owns MW until its last-beat handshake
module rvvi_tx_arbiter #(
  parameter int unsigned MAX_OUTSTANDING   = 8,
  parameter int unsigned FRAME_COUNT_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  rvvi_tx_arbiter_if.slave             tReq,
  rvvi_tx_arbiter_if.slave             cReq,
  rvvi_tx_arbiter_if.master            mTx,
  input  logic                         AckValid,
  input  logic [FRAME_COUNT_WIDTH-1:0] AckCount,
  output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
  output logic [7:0]                   Outstanding,
  output logic                         CreditStall
);

  typedef enum logic [1:0] {IDLE, GNT_T, GNT_C} arbState;

  arbState                      state;
  arbState                      stateNext;
  logic                         lastGrantT;
  logic [FRAME_COUNT_WIDTH-1:0] ackedCount;
  logic [FRAME_COUNT_WIDTH-1:0] outstandingWide;
  logic [FRAME_COUNT_WIDTH-1:0] ackDelta;
  logic                         creditOk;
  logic                         tEligible;
  logic                         cEligible;
  logic                         tFrameDone;
  logic                         ackAccept;

  assign outstandingWide = FrameCount - ackedCount;
  assign Outstanding     = 8'(outstandingWide);
  assign creditOk        = Outstanding < 8'(MAX_OUTSTANDING);
  assign CreditStall     = Outstanding == 8'(MAX_OUTSTANDING);

  // Range check done on modular distances from the acked count so that a
  // FrameCount that has wrapped past zero still bounds the ack correctly.
  assign ackDelta  = AckCount - ackedCount;
  assign ackAccept = AckValid && (ackDelta <= outstandingWide);

  assign tEligible = tReq.Wvalid && creditOk;
  assign cEligible = cReq.Wvalid;

  always_comb begin
    stateNext   = state;
    tFrameDone  = 1'b0;
    mTx.Wdata   = '0;
    mTx.Wstrb   = '0;
    mTx.Wlast   = 1'b0;
    mTx.Wvalid  = 1'b0;
    tReq.Wready = 1'b0;
    cReq.Wready = 1'b0;
    case (state)
      IDLE: begin
        if (tEligible && cEligible) stateNext = lastGrantT ? GNT_C : GNT_T;
        else if (tEligible)         stateNext = GNT_T;
        else if (cEligible)         stateNext = GNT_C;
      end
      GNT_T: begin
        mTx.Wdata   = tReq.Wdata;
        mTx.Wstrb   = tReq.Wstrb;
        mTx.Wlast   = tReq.Wlast;
        mTx.Wvalid  = tReq.Wvalid;
        tReq.Wready = mTx.Wready;
        if (tReq.Wvalid && mTx.Wready && tReq.Wlast) begin
          stateNext  = IDLE;
          tFrameDone = 1'b1;
        end
      end
      GNT_C: begin
        mTx.Wdata   = cReq.Wdata;
        mTx.Wstrb   = cReq.Wstrb;
        mTx.Wlast   = cReq.Wlast;
        mTx.Wvalid  = cReq.Wvalid;
        cReq.Wready = mTx.Wready;
        if (cReq.Wvalid && mTx.Wready && cReq.Wlast) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lastGrantT <= 1'b0;
      FrameCount <= '0;
      ackedCount <= '0;
    end else begin
      state <= stateNext;
      // Remember whoever was granted last so a later tie goes the other way.
      if (state == IDLE && stateNext == GNT_T)      lastGrantT <= 1'b1;
      else if (state == IDLE && stateNext == GNT_C) lastGrantT <= 1'b0;
      if (tFrameDone) FrameCount <= FrameCount + FRAME_COUNT_WIDTH'(1);
      if (ackAccept)  ackedCount <= AckCount;
    end
  end

endmodule

// File: tb/tb_rvvi_tx_arbiter.sv
module tb_rvvi_tx_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  rvvi_tx_arbiter_if tIf ();
  rvvi_tx_arbiter_if cIf ();
  rvvi_tx_arbiter_if mIf ();
  logic        AckValid;
  logic [63:0] AckCount;
  logic [63:0] FrameCount;
  logic [7:0]  Outstanding;
  logic        CreditStall;

  rvvi_tx_arbiter #(.MAX_OUTSTANDING(8), .FRAME_COUNT_WIDTH(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .tReq        (tIf),
    .cReq        (cIf),
    .mTx         (mIf),
    .AckValid    (AckValid),
    .AckCount    (AckCount),
    .FrameCount  (FrameCount),
    .Outstanding (Outstanding),
    .CreditStall (CreditStall)
  );

  // Narrow-counter instance so the counter wrap is reachable in a short run.
  rvvi_tx_arbiter_if tIfN ();
  rvvi_tx_arbiter_if cIfN ();
  rvvi_tx_arbiter_if mIfN ();
  logic       AckValidN;
  logic [3:0] AckCountN;
  logic [3:0] FrameCountN;
  logic [7:0] OutstandingN;
  logic       CreditStallN;

  rvvi_tx_arbiter #(.MAX_OUTSTANDING(4), .FRAME_COUNT_WIDTH(4)) dutN (
    .clk         (clk),
    .reset       (reset),
    .tReq        (tIfN),
    .cReq        (cIfN),
    .mTx         (mIfN),
    .AckValid    (AckValidN),
    .AckCount    (AckCountN),
    .FrameCount  (FrameCountN),
    .Outstanding (OutstandingN),
    .CreditStall (CreditStallN)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every step starts and ends at a falling edge; inputs change there and
  // outputs are sampled #1 later, well away from the rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tIf.Wvalid = 1'b0; tIf.Wlast = 1'b0; tIf.Wdata = '0; tIf.Wstrb = 4'hF;
    cIf.Wvalid = 1'b0; cIf.Wlast = 1'b0; cIf.Wdata = '0; cIf.Wstrb = 4'hF;
    mIf.Wready = 1'b1;
    AckValid = 1'b0; AckCount = '0;
    tIfN.Wvalid = 1'b0; tIfN.Wlast = 1'b0; tIfN.Wdata = '0; tIfN.Wstrb = 4'hF;
    cIfN.Wvalid = 1'b0; cIfN.Wlast = 1'b0; cIfN.Wdata = '0; cIfN.Wstrb = 4'hF;
    mIfN.Wready = 1'b1;
    AckValidN = 1'b0; AckCountN = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // n single-beat trace frames, each taking an IDLE cycle plus a grant cycle.
  task automatic stream_t(input int n);
    tIf.Wvalid = 1'b1; tIf.Wlast = 1'b1; tIf.Wdata = 32'h7000_0000;
    repeat (2 * n) tick();
    tIf.Wvalid = 1'b0;
  endtask

  task automatic ack(input logic [63:0] v);
    AckValid = 1'b1; AckCount = v;
    tick();
    AckValid = 1'b0;
  endtask

  task automatic stream_n(input int n);
    tIfN.Wvalid = 1'b1; tIfN.Wlast = 1'b1; tIfN.Wdata = 32'h7100_0000;
    repeat (2 * n) tick();
    tIfN.Wvalid = 1'b0;
  endtask

  task automatic ack_n(input logic [3:0] v);
    AckValidN = 1'b1; AckCountN = v;
    tick();
    AckValidN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    int leaks;
    int orderErr;
    int k;
    logic [15:0] lfsr;
    logic r;

    @(negedge clk);

    // Reset values, then a 20-beat trace frame.
    do_reset();
    check_val("rst_FrameCount", FrameCount, 64'd0);
    check_val("rst_Outstanding", Outstanding, 8'd0);
    check_val("rst_CreditStall", CreditStall, 1'b0);
    check_val("rst_MWvalid", mIf.Wvalid, 1'b0);
    check_val("rst_TWready", tIf.Wready, 1'b0);
    check_val("rst_CWready", cIf.Wready, 1'b0);
    check_val("rst_MWlast", mIf.Wlast, 1'b0);

    tIf.Wvalid = 1'b1; tIf.Wdata = 32'd100; tIf.Wlast = 1'b0;
    #1 check_val("t20_idle_MWvalid", mIf.Wvalid, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      tIf.Wdata = 32'd100 + 32'(i);
      tIf.Wlast = (i == 19);
      #1;
      check_val($sformatf("t20_MWdata_%0d", i), mIf.Wdata, 64'd100 + 64'(i));
      check_val($sformatf("t20_MWlast_%0d", i), mIf.Wlast, (i == 19) ? 64'd1 : 64'd0);
      check_val($sformatf("t20_TWready_%0d", i), tIf.Wready, 1'b1);
      if (i == 19) check_val("t20_FrameCount_pre", FrameCount, 64'd0);
      tick();
    end
    tIf.Wvalid = 1'b0;
    #1;
    check_val("t20_FrameCount", FrameCount, 64'd1);
    check_val("t20_Outstanding", Outstanding, 8'd1);
    check_val("t20_gap_MWvalid", mIf.Wvalid, 1'b0);

    // Both requesters valid from reset: grants alternate T,C,T,C,T,C with
    // one IDLE cycle between frames.
    do_reset();
    tIf.Wvalid = 1'b1; tIf.Wlast = 1'b1; tIf.Wdata = 32'hAAAA_0001;
    cIf.Wvalid = 1'b1; cIf.Wlast = 1'b1; cIf.Wdata = 32'hCCCC_0002;
    for (int c = 0; c < 12; c++) begin
      #1;
      check_val($sformatf("rr_TWready_%0d", c), tIf.Wready, (c % 4 == 1) ? 64'd1 : 64'd0);
      check_val($sformatf("rr_CWready_%0d", c), cIf.Wready, (c % 4 == 3) ? 64'd1 : 64'd0);
      if (c % 4 == 1) check_val($sformatf("rr_MWdata_%0d", c), mIf.Wdata, 64'hAAAA_0001);
      if (c % 4 == 3) check_val($sformatf("rr_MWdata_%0d", c), mIf.Wdata, 64'hCCCC_0002);
      tick();
    end
    tIf.Wvalid = 1'b0; cIf.Wvalid = 1'b0;
    #1 check_val("rr_FrameCount", FrameCount, 64'd3);

    // Credit window: 8 frames then stall; C still served; ack of 5 reopens.
    do_reset();
    stream_t(8);
    tIf.Wvalid = 1'b1;
    #1;
    check_val("cr_FrameCount", FrameCount, 64'd8);
    check_val("cr_Outstanding", Outstanding, 8'd8);
    check_val("cr_CreditStall", CreditStall, 1'b1);
    seen = 0;
    repeat (4) begin
      #1 if (tIf.Wready) seen++;
      tick();
    end
    check_val("cr_stalled_TWready", 64'(seen), 64'd0);
    cIf.Wvalid = 1'b1; cIf.Wlast = 1'b1; cIf.Wdata = 32'hCCCC_00C0;
    #1 check_val("cr_c_idle_CWready", cIf.Wready, 1'b0);
    tick();
    #1;
    check_val("cr_c_CWready", cIf.Wready, 1'b1);
    check_val("cr_c_MWdata", mIf.Wdata, 64'hCCCC_00C0);
    tick();
    cIf.Wvalid = 1'b0;
    ack(64'd5);
    #1;
    check_val("cr_ack_Outstanding", Outstanding, 8'd3);
    check_val("cr_ack_CreditStall", CreditStall, 1'b0);
    check_val("cr_ack_idle_TWready", tIf.Wready, 1'b0);
    tick();
    #1 check_val("cr_resume_TWready", tIf.Wready, 1'b1);
    tick();
    tIf.Wvalid = 1'b0;

    // Ack range checks with FrameCount=4, AckedCount=2.
    do_reset();
    stream_t(4);
    ack(64'd2);
    #1;
    check_val("ak_FrameCount", FrameCount, 64'd4);
    check_val("ak_base_Outstanding", Outstanding, 8'd2);
    ack(64'd6);
    #1 check_val("ak_future_Outstanding", Outstanding, 8'd2);
    ack(64'd1);
    #1 check_val("ak_stale_Outstanding", Outstanding, 8'd2);
    ack(64'd4);
    #1 check_val("ak_ok_Outstanding", Outstanding, 8'd0);

    // 30-beat C frame under pseudo-random backpressure with T waiting.
    do_reset();
    cIf.Wvalid = 1'b1; cIf.Wdata = 32'hC000_0000; cIf.Wlast = 1'b0;
    tick();
    tIf.Wvalid = 1'b1; tIf.Wlast = 1'b1; tIf.Wdata = 32'hDEAD_BEEF;
    lfsr = 16'hACE1;
    k = 0; leaks = 0; orderErr = 0;
    for (int cyc = 0; cyc < 200 && k < 30; cyc++) begin
      r = lfsr[0];
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      mIf.Wready = r;
      cIf.Wdata = 32'hC000_0000 + 32'(k);
      cIf.Wlast = (k == 29);
      #1;
      if (tIf.Wready) leaks++;
      if (mIf.Wdata !== 32'hC000_0000 + 32'(k) || mIf.Wlast !== (k == 29) || cIf.Wready !== r)
        orderErr++;
      tick();
      if (r) k++;
    end
    mIf.Wready = 1'b1;
    cIf.Wvalid = 1'b0;
    check_val("bp_beats", 64'(k), 64'd30);
    check_val("bp_T_leaks", 64'(leaks), 64'd0);
    check_val("bp_order_errors", 64'(orderErr), 64'd0);
    #1;
    check_val("bp_gap_TWready", tIf.Wready, 1'b0);
    check_val("bp_gap_MWvalid", mIf.Wvalid, 1'b0);
    tick();
    #1;
    check_val("bp_T_TWready", tIf.Wready, 1'b1);
    check_val("bp_T_MWdata", mIf.Wdata, 64'hDEAD_BEEF);
    tick();
    tIf.Wvalid = 1'b0;

    // Reset in the middle of a trace frame.
    do_reset();
    stream_t(1);
    tIf.Wvalid = 1'b1; tIf.Wlast = 1'b0; tIf.Wdata = 32'h0000_1234;
    tick();
    tick();
    tick();
    #1 check_val("mid_pre_MWvalid", mIf.Wvalid, 1'b1);
    reset = 1'b1;
    tick();
    #1;
    check_val("mid_MWvalid", mIf.Wvalid, 1'b0);
    check_val("mid_TWready", tIf.Wready, 1'b0);
    check_val("mid_MWdata", mIf.Wdata, 64'd0);
    check_val("mid_MWlast", mIf.Wlast, 1'b0);
    check_val("mid_FrameCount", FrameCount, 64'd0);
    check_val("mid_Outstanding", Outstanding, 8'd0);
    check_val("mid_CreditStall", CreditStall, 1'b0);
    tIf.Wvalid = 1'b0;
    reset = 1'b0;

    // Counter wrap on the 4-bit instance (window of 4).
    do_reset();
    for (int rnd = 0; rnd < 3; rnd++) begin
      stream_n(4);
      ack_n(4'(4 * (rnd + 1)));
    end
    #1;
    check_val("wr_FrameCount_12", FrameCountN, 4'd12);
    check_val("wr_Outstanding_12", OutstandingN, 8'd0);
    stream_n(3);
    ack_n(4'd14);
    #1 check_val("wr_Outstanding_ack14", OutstandingN, 8'd1);
    stream_n(2);
    #1;
    check_val("wr_FrameCount_wrapped", FrameCountN, 4'd1);
    check_val("wr_Outstanding_wrapped", OutstandingN, 8'd3);
    ack_n(4'd0);
    #1 check_val("wr_ack0_Outstanding", OutstandingN, 8'd1);
    ack_n(4'd15);
    #1 check_val("wr_stale15_Outstanding", OutstandingN, 8'd1);
    ack_n(4'd2);
    #1 check_val("wr_future2_Outstanding", OutstandingN, 8'd1);
    ack_n(4'd1);
    #1 check_val("wr_ack1_Outstanding", OutstandingN, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
